// File: rtl/sync_fifo_nbit.sv
// sync_fifo_nbit: parametrised single-clock FIFO with a registered read port.
// Define FIFO_ERR_FLAG_EN to add sticky overflow/underflow flags with err_clr.
module sync_fifo_nbit #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count
`ifdef FIFO_ERR_FLAG_EN
    ,
    input  logic                   err_clr,
    output logic                   overflow,
    output logic                   underflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;

    // Handshake: wr_en/rd_en are single-cycle requests with no ready return;
    // a request is taken on the edge where its *_acc term is high, else dropped.
    // A read frees a slot in the same edge, so a full FIFO still takes a write.
    assign wr_acc = wr_en & (~full | rd_en);
    assign rd_acc = rd_en & ~empty;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAG_EN
    // A set condition in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & full & ~rd_en) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en & empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_nbit.sv
// Self-checking bench for sync_fifo_nbit: directed fill/drain, overflow,
// underflow, simultaneous access, wrap, mid-operation reset and a random phase.
module tb_sync_fifo_nbit;

    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic         rd_en;
    logic [W-1:0] rd_data;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic         almost_empty;
    logic [4:0]   count;
`ifdef FIFO_ERR_FLAG_EN
    logic         err_clr;
    logic         overflow;
    logic         underflow;
`endif

    sync_fifo_nbit #(
        .WIDTH(W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count)
`ifdef FIFO_ERR_FLAG_EN
        ,
        .err_clr(err_clr),
        .overflow(overflow),
        .underflow(underflow)
`endif
    );

    // Clock/reset block
    always #5 clk = ~clk;

    // Scoreboard state: mdl_q mirrors stored contents, exp_q holds pending reads.
    logic [W-1:0] mdl_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_rd;
    int           errors = 0;
    int           checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        int n;
        n = mdl_q.size();
        check({tag, "_count"}, 32'(count), 32'(n));
        check({tag, "_full"}, 32'(full), 32'(n == DEPTH));
        check({tag, "_empty"}, 32'(empty), 32'(n == 0));
        check({tag, "_afull"}, 32'(almost_full), 32'(n >= AF));
        check({tag, "_aempty"}, 32'(almost_empty), 32'(n <= AE));
    endtask

    // Driver: one clock cycle with the given requests, then score the result.
    task automatic cycle(input logic we, input logic [W-1:0] wd, input logic re);
        logic wa;
        logic ra;
        ra = re && (mdl_q.size() != 0);
        wa = we && ((mdl_q.size() != DEPTH) || re);
        if (ra) exp_q.push_back(mdl_q.pop_front());
        if (wa) mdl_q.push_back(wd);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (ra) begin
            last_rd = exp_q.pop_front();
            check("rd_data", 32'(rd_data), 32'(last_rd));
        end else begin
            check("rd_hold", 32'(rd_data), 32'(last_rd));
        end
        check_flags("cyc");
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        reset_n = 1'b0;
        #2;
        mdl_q.delete();
        exp_q.delete();
        last_rd = '0;
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check_flags("rst");
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [W-1:0] v;
        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        last_rd = '0;
`ifdef FIFO_ERR_FLAG_EN
        err_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("init_rd_data", 32'(rd_data), 32'h0);
        check_flags("init");
        reset_n = 1'b1;
        cycle(1'b0, '0, 1'b0);
        pulse_reset();

        // Fill 01..10, then one dropped write of AA.
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, W'(i), 1'b0);
            check("fill_afull", 32'(almost_full), 32'(i >= 14));
        end
        check("fill_full", 32'(full), 32'h1);
        cycle(1'b1, 8'hAA, 1'b0);
        check("ovf_count", 32'(count), 32'd16);
`ifdef FIFO_ERR_FLAG_EN
        check("ovf_flag", 32'(overflow), 32'h1);
`endif

        // Drain in order; one extra read underflows.
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, '0, 1'b1);
            check("drain_order", 32'(rd_data), 32'(i));
            check("drain_aempty", 32'(almost_empty), 32'(i >= 14));
        end
        check("drain_empty", 32'(empty), 32'h1);
        cycle(1'b0, '0, 1'b1);
        check("udf_rd_data", 32'(rd_data), 32'h10);
        check("udf_count", 32'(count), 32'd0);
`ifdef FIFO_ERR_FLAG_EN
        check("udf_flag", 32'(underflow), 32'h1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("clr_ovf", 32'(overflow), 32'h0);
        check("clr_udf", 32'(underflow), 32'h0);
`endif

        // Simultaneous read/write while full.
        for (int i = 0; i < 16; i++) cycle(1'b1, W'(8'h20 + i), 1'b0);
        cycle(1'b1, 8'h55, 1'b1);
        check("sim_full_oldest", 32'(rd_data), 32'h20);
        check("sim_full_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1);
        check("sim_full_last", 32'(rd_data), 32'h55);

        // Simultaneous read/write while empty: no fall-through.
        cycle(1'b1, 8'h77, 1'b1);
        check("sim_empty_count", 32'(count), 32'd1);
        check("sim_empty_hold", 32'(rd_data), 32'h55);
        cycle(1'b0, '0, 1'b1);
        check("sim_empty_next", 32'(rd_data), 32'h77);

        // Random traffic scored against the queue model.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
        end
        while (mdl_q.size() != 0) cycle(1'b0, '0, 1'b1);

        // Wrap: 5-word preload, 40 streaming cycles, output lags by 5.
        pulse_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, W'(i), 1'b0);
        for (int i = 5; i < 45; i++) begin
            cycle(1'b1, W'(i), 1'b1);
            v = W'(i - 5);
            check("wrap_lag", 32'(rd_data), 32'(v));
        end
        for (int i = 45; i < 49; i++) cycle(1'b1, W'(i), 1'b0);
        check("pre_rst_count", 32'(count), 32'd9);
        pulse_reset();
        cycle(1'b1, 8'hC3, 1'b0);
        check("post_rst_count", 32'(count), 32'd1);
        cycle(1'b0, '0, 1'b1);
        check("post_rst_data", 32'(rd_data), 32'hC3);
        check("post_rst_empty", 32'(empty), 32'h1);

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
